crc3_arbiter_ctrl: RTL and testbench
====================================

# crc3_arbiter_ctrl

Controller that shares one serial CRC-3 division datapath (polynomial x^3 + x + 1, MSB-first) between two message requesters. It arbitrates between them, captures the winner's 5-bit message, and serializes it MSB-first followed by 3 zero flush bits through an internal 3-bit divider. It drives the clock-gate enable and serial bit that an external gated engine consumes. It returns the 8-bit codeword {msg, crc} tagged with the requester id over a valid/ready result port.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 2: bit i = requester i has a message pending.
- `req_msg0` in 5: requester 0 message, MSB-first.
- `req_msg1` in 5: requester 1 message, MSB-first.
- `req_ready` out 2: one-hot grant. A request is accepted on a clock edge when `req_valid[i] & req_ready[i]`.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumer ready.
- `res_code` out 8: codeword {msg[4:0], crc[2:0]}.
- `res_id` out 1: requester index owning `res_code`.
- `busy` out 1: high in SHIFT or DONE.
- `eng_en` out 1: clock-gate enable for the external engine; high exactly during the 8 SHIFT cycles.
- `eng_bit` out 1: serial bit presented to the engine during SHIFT; 0 otherwise.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `req_ready` is combinational and equals the arbiter grant among `req_valid` bits (one-hot or 00).
  - On accept: latch the granted message into `msg`, latch `res_id`, set `crc` = 000 and `bit_idx` = 0, then go to SHIFT.
- **SHIFT**
  - `req_ready` = 00.
  - Serial bit: `eng_bit` = msg[4 − bit_idx] for bit_idx 0..4, else 0.
  - Each cycle: crc <= {crc[1:0], eng_bit} ^ (crc[2] ? 3'b011 : 3'b000); bit_idx increments.
  - After the edge that processes bit_idx = 7: `res_code` <= {msg, crc_next} and `res_valid` <= 1, then go to DONE.
- **DONE**
  - `res_valid`, `res_code` and `res_id` hold stable until `res_ready` is sampled high.
  - On that edge `res_valid` <= 0 and the state returns to IDLE.
- No request is accepted in DONE; there is no bypass from DONE to SHIFT.
- Arbitration is round-robin (see Configuration).
  - `last` pointer = id of the most recently accepted requester; on contention, the requester other than `last` wins.
  - `last` updates only on accept.
- `req_msgN` may change freely after acceptance, since the message is captured at accept.
- Dropping `req_valid` while in SHIFT or DONE has no effect on the job in flight.

## Timing
- Reset values (asserted asynchronously):
  - Outputs: `res_valid` 0, `res_code` 0, `res_id` 0, `busy` 0, `eng_en` 0, `eng_bit` 0.
  - Internal: state IDLE, `last` = 1, so requester 0 wins the first contention.
  - `req_ready` is 00 while `reset` is high.
- Latency:
  - Accept at edge E0.
  - Bits are processed at edges E1..E8.
  - `res_valid` goes high after E8, i.e. 8 cycles after accept.
  - Earliest next accept is the edge after the result handshake: back-to-back jobs take 10 cycles when `res_ready` is held high.
- Reset mid-SHIFT or mid-DONE aborts the job: no result is produced and the pending requester is not granted implicitly.
- Simultaneous `req_valid` = 11 in IDLE: exactly one grant bit is set, never both.

## Configuration
- `CRC3_ARB_RR_EN` defined: round-robin arbitration as above.
- `CRC3_ARB_RR_EN` undefined: fixed priority, requester 0 always wins contention; the `last` pointer is not implemented.
- All other behaviour is identical in both configurations.

## Test plan
- Reset, then requester 0 sends 10110 with `res_ready` = 1 -> `eng_en` high for exactly 8 cycles, `res_code` = 0xB0, `res_id` = 0, `res_valid` high 8 cycles after accept.
- Requester 1 sends 00001 -> `res_code` = 0x0B, `res_id` = 1; `eng_bit` sequence is 0,0,0,0,1,0,0,0.
- Requester 0 sends 11111 with `res_ready` held 0 for 5 cycles -> `res_code` = 0xFE, with `res_valid`, `res_code` and `res_id` stable until the handshake; `req_ready` stays 00 throughout.
- Both requesters valid continuously (messages 10110 / 00001), with `CRC3_ARB_RR_EN` defined -> results alternate id 0, 1, 0, 1, spaced 10 cycles apart. With the macro undefined -> all results are id 0.
- Assert `reset` at the 4th SHIFT cycle -> all outputs return to reset values immediately and no `res_valid` pulse follows. A re-issued 10110 afterwards yields 0xB0.
- Change `req_msg0` from 10110 to 00000 one cycle after accept -> `res_code` is still 0xB0.

Source files
------------

// File: rtl/crc3_arbiter_ctrl.sv
// Two-requester arbiter in front of a serial CRC-3 (x^3+x+1) divider that drives an external gated engine.
// Define CRC3_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module crc3_arbiter_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [4:0] req_msg0,
    input  logic [4:0] req_msg1,
    output logic [1:0] req_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_code,
    output logic       res_id,
    output logic       busy,
    output logic       eng_en,
    output logic       eng_bit
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t     state_r;
    logic [4:0] msg_r;
    logic [2:0] crc_r;
    logic [2:0] bit_idx_r;
    logic       res_valid_r;
    logic [7:0] res_code_r;
    logic       res_id_r;
    logic       busy_r;
    logic       eng_en_r;
    logic       eng_bit_r;
`ifdef CRC3_ARB_RR_EN
    logic       last_r;
`endif

    logic [1:0] grant_s;
    logic       accept_s;
    logic       accept_id_s;
    logic [4:0] accept_msg_s;
    logic       ser_bit_s;
    logic [2:0] crc_next_s;

    // Serial bit for a given position: five message bits MSB-first, then zero flush bits.
    function automatic logic msg_bit(input logic [4:0] msg, input logic [2:0] idx);
        logic b;
        b = 1'b0;
        case (idx)
            3'd0:    b = msg[4];
            3'd1:    b = msg[3];
            3'd2:    b = msg[2];
            3'd3:    b = msg[1];
            3'd4:    b = msg[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic din);
        return {crc[1:0], din} ^ (crc[2] ? 3'b011 : 3'b000);
    endfunction

    // Grant selection; only offered in IDLE and never while reset is asserted.
    always_comb begin
        grant_s = 2'b00;
        if (reset || (state_r != ST_IDLE)) begin
            grant_s = 2'b00;
        end else begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
`ifdef CRC3_ARB_RR_EN
                2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
`else
                2'b11:   grant_s = 2'b01;
`endif
                default: grant_s = 2'b00;
            endcase
        end
    end

    // Accept decode and datapath next values.
    always_comb begin
        accept_s     = |(grant_s & req_valid);
        accept_id_s  = grant_s[1];
        accept_msg_s = grant_s[1] ? req_msg1 : req_msg0;
        ser_bit_s    = msg_bit(msg_r, bit_idx_r);
        crc_next_s   = crc3_step(crc_r, ser_bit_s);
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            msg_r       <= 5'd0;
            crc_r       <= 3'd0;
            bit_idx_r   <= 3'd0;
            res_valid_r <= 1'b0;
            res_code_r  <= 8'd0;
            res_id_r    <= 1'b0;
            busy_r      <= 1'b0;
            eng_en_r    <= 1'b0;
            eng_bit_r   <= 1'b0;
`ifdef CRC3_ARB_RR_EN
            last_r      <= 1'b1;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        msg_r     <= accept_msg_s;
                        res_id_r  <= accept_id_s;
                        crc_r     <= 3'd0;
                        bit_idx_r <= 3'd0;
                        busy_r    <= 1'b1;
                        eng_en_r  <= 1'b1;
                        eng_bit_r <= accept_msg_s[4];
`ifdef CRC3_ARB_RR_EN
                        last_r    <= accept_id_s;
`endif
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    crc_r     <= crc_next_s;
                    bit_idx_r <= bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        res_code_r  <= {msg_r, crc_next_s};
                        res_valid_r <= 1'b1;
                        eng_en_r    <= 1'b0;
                        eng_bit_r   <= 1'b0;
                        state_r     <= ST_DONE;
                    end else begin
                        eng_bit_r <= msg_bit(msg_r, bit_idx_r + 3'd1);
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = grant_s;
    assign res_valid = res_valid_r;
    assign res_code  = res_code_r;
    assign res_id    = res_id_r;
    assign busy      = busy_r;
    assign eng_en    = eng_en_r;
    assign eng_bit   = eng_bit_r;

endmodule

// File: tb/tb_crc3_arbiter_ctrl.sv
// Self-checking bench for crc3_arbiter_ctrl: vector table of single jobs, scoreboard of expected results,
// plus hand-written reset-abort and contention sequences.
module tb_crc3_arbiter_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] req_valid;
    logic [4:0] req_msg0;
    logic [4:0] req_msg1;
    logic [1:0] req_ready;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_code;
    logic       res_id;
    logic       busy;
    logic       eng_en;
    logic       eng_bit;

    crc3_arbiter_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_msg0  (req_msg0),
        .req_msg1  (req_msg1),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_code  (res_code),
        .res_id    (res_id),
        .busy      (busy),
        .eng_en    (eng_en),
        .eng_bit   (eng_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] valid;
        logic [4:0] m0;
        logic [4:0] m1;
        int         stall;
        logic [7:0] code;
        logic       id;
    } vec_t;

    typedef struct packed {
        logic [7:0] code;
        logic       id;
    } exp_t;

    vec_t vecs[7];
    exp_t sb_q[$];
    int   total;
    int   bad;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: result code=%0h id=%0d with nothing expected", res_code, res_id);
        end else begin
            e = sb_q.pop_front();
            chk("sb_res_code", 32'(res_code), 32'(e.code));
            chk("sb_res_id", 32'(res_id), 32'(e.id));
        end
    endtask

    task automatic run_job(input vec_t v);
        int         k;
        logic [4:0] m;
        logic       exp_bit;
        exp_t       e;
        m = v.valid[1] ? v.m1 : v.m0;
        @(negedge clk);
        req_valid = v.valid;
        req_msg0  = v.m0;
        req_msg1  = v.m1;
        res_ready = (v.stall == 0);
        #1;
        chk("grant_single", 32'(req_ready), 32'(v.valid));
        e.code = v.code;
        e.id   = v.id;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_msg0 = 5'd0;
        req_msg1 = 5'd0;
        k = 0;
        @(negedge clk);
        while (!res_valid && k < 20) begin
            exp_bit = (k < 5) ? m[4 - k] : 1'b0;
            chk("eng_en_shift", 32'(eng_en), 32'd1);
            chk("eng_bit_shift", 32'(eng_bit), 32'(exp_bit));
            chk("busy_shift", 32'(busy), 32'd1);
            chk("ready_shift", 32'(req_ready), 32'd0);
            k++;
            @(negedge clk);
        end
        chk("latency", 32'(k), 32'd8);
        chk("eng_en_done", 32'(eng_en), 32'd0);
        chk("eng_bit_done", 32'(eng_bit), 32'd0);
        for (int s = 0; s < v.stall; s++) begin
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_code", 32'(res_code), 32'(v.code));
            chk("stall_id", 32'(res_id), 32'(v.id));
            chk("stall_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        chk("res_valid_hs", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        req_valid = 2'b00;
        #1;
        if (res_valid) begin
            sb_check();
        end else begin
            void'(sb_q.pop_front());
        end
        @(negedge clk);
        chk("res_valid_after", 32'(res_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nacc;
        int         nres;
        int         last_cyc;
        int         quiet_bad;
        logic [3:0] exp_ids;
        exp_t       e;

        total = 0;
        bad   = 0;
        vecs[0] = '{valid: 2'b01, m0: 5'b10110, m1: 5'b00000, stall: 0, code: 8'hB0, id: 1'b0};
        vecs[1] = '{valid: 2'b10, m0: 5'b00000, m1: 5'b00001, stall: 0, code: 8'h0B, id: 1'b1};
        vecs[2] = '{valid: 2'b01, m0: 5'b11111, m1: 5'b00000, stall: 5, code: 8'hFE, id: 1'b0};
        vecs[3] = '{valid: 2'b10, m0: 5'b00000, m1: 5'b11111, stall: 2, code: 8'hFE, id: 1'b1};
        vecs[4] = '{valid: 2'b01, m0: 5'b00000, m1: 5'b10101, stall: 0, code: 8'h00, id: 1'b0};
        vecs[5] = '{valid: 2'b10, m0: 5'b11111, m1: 5'b10110, stall: 1, code: 8'hB0, id: 1'b1};
        vecs[6] = '{valid: 2'b01, m0: 5'b00001, m1: 5'b11111, stall: 0, code: 8'h0B, id: 1'b0};

        reset     = 1'b1;
        req_valid = 2'b11;
        req_msg0  = 5'd0;
        req_msg1  = 5'd0;
        res_ready = 1'b0;
        #12;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_code", 32'(res_code), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_eng_en", 32'(eng_en), 32'd0);
        chk("rst_eng_bit", 32'(eng_bit), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        reset     = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i]);
        end

        // Reset during the 4th SHIFT cycle aborts the job.
        @(negedge clk);
        req_valid = 2'b01;
        req_msg0  = 5'b10110;
        res_ready = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_res_code", 32'(res_code), 32'd0);
        chk("abort_res_id", 32'(res_id), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_eng_en", 32'(eng_en), 32'd0);
        chk("abort_eng_bit", 32'(eng_bit), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 2'b00;
        quiet_bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (res_valid || busy) quiet_bad++;
        end
        chk("abort_no_result", 32'(quiet_bad), 32'd0);
        run_job(vecs[0]);

        // Continuous contention from a fresh reset.
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
`ifdef CRC3_ARB_RR_EN
        exp_ids = 4'b1010;
`else
        exp_ids = 4'b0000;
`endif
        @(negedge clk);
        req_valid = 2'b11;
        req_msg0  = 5'b10110;
        req_msg1  = 5'b00001;
        res_ready = 1'b1;
        nacc      = 0;
        nres      = 0;
        last_cyc  = 0;
        for (int cyc = 0; cyc < 80 && nres < 4; cyc++) begin
            #1;
            if (req_ready != 2'b00) begin
                chk("cont_onehot", 32'($countones(req_ready)), 32'd1);
                if (nacc < 4) begin
                    chk("cont_grant_id", 32'(req_ready[1]), 32'(exp_ids[nacc]));
                    e.id   = exp_ids[nacc];
                    e.code = exp_ids[nacc] ? 8'h0B : 8'hB0;
                    sb_q.push_back(e);
                end
                nacc++;
            end
            if (res_valid) begin
                sb_check();
                if (nres > 0) chk("cont_spacing", 32'(cyc - last_cyc), 32'd10);
                last_cyc = cyc;
                nres++;
                if (nres == 4) req_valid = 2'b00;
            end
            @(negedge clk);
        end
        chk("cont_results", 32'(nres), 32'd4);
        chk("cont_accepts", 32'(nacc), 32'd4);
        @(negedge clk);
        chk("final_idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
